// File: rtl/seg7_scan_driver.sv
// Multiplexed driver for a bank of hex 7-segment digits.
// Values are double-buffered (pend -> disp) and only committed at the frame
// wrap, so a frame never mixes digits from two different values.

// One digit lane: hex decode plus leading-zero blanking for that position.
module seg7_scan_lane #(
    parameter bit BLANKABLE = 1'b1
) (
    input  logic [3:0] nib,
    input  logic       zero_up,
    input  logic       blank_lz,
    output logic [6:0] seg
);
    logic [6:0] code;

    // Hex nibble to {a,b,c,d,e,f,g}, active-high.
    always_comb begin
        code = 7'h00;
        case (nib)
            4'h0: code = 7'h7E;
            4'h1: code = 7'h30;
            4'h2: code = 7'h6D;
            4'h3: code = 7'h79;
            4'h4: code = 7'h33;
            4'h5: code = 7'h5B;
            4'h6: code = 7'h5F;
            4'h7: code = 7'h70;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h7B;
            4'hA: code = 7'h77;
            4'hB: code = 7'h1F;
            4'hC: code = 7'h4E;
            4'hD: code = 7'h3D;
            4'hE: code = 7'h4F;
            4'hF: code = 7'h47;
            default: code = 7'h00;
        endcase
    end

    // Blank when this digit and everything above it is zero (digit 0 is never blankable).
    always_comb begin
        seg = (BLANKABLE && blank_lz && zero_up) ? 7'h00 : code;
    end
endmodule

module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*DIGITS-1:0]     disp_val, disp_val_nx, pend_val;
    logic [DIGITS-1:0]       disp_dp, disp_dp_nx, pend_dp;
    logic                    pend_v;
    // Low on the first edge after reset: that edge only primes the outputs
    // from the reset state, so the first digit gets a full SCAN_DIV slot.
    logic                    run;
    logic                    wrap_cnt, frame_wrap, upd;
    logic [DIGITS-1:0]       zero_up;
    logic [DIGITS-1:0][6:0]  lane_seg;

    // Scan step decode and post-commit display contents.
    always_comb begin
        wrap_cnt    = run && (cnt == CNT_MAX);
        frame_wrap  = wrap_cnt && (idx == IDX_MAX);
        upd         = !run || wrap_cnt;
        idx_nx      = idx;
        disp_val_nx = disp_val;
        disp_dp_nx  = disp_dp;
        if (wrap_cnt)
            idx_nx = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        if (frame_wrap) begin
            if (load) begin
                disp_val_nx = value;
                disp_dp_nx  = dp_in;
            end else if (pend_v) begin
                disp_val_nx = pend_val;
                disp_dp_nx  = pend_dp;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lane
            assign zero_up[gi] = ~|disp_val_nx[4*DIGITS-1:4*gi];
            seg7_scan_lane #(.BLANKABLE(gi != 0)) u_lane (
                .nib      (disp_val_nx[4*gi +: 4]),
                .zero_up  (zero_up[gi]),
                .blank_lz (blank_lz),
                .seg      (lane_seg[gi])
            );
        end
    endgenerate

    // Scan counters, double buffer and registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            run        <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_v     <= 1'b0;
            seg        <= 7'h00;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                cnt <= wrap_cnt ? '0 : cnt + CW'(1);
                idx <= idx_nx;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            pend_v     <= frame_wrap ? 1'b0 : (load ? 1'b1 : pend_v);
            disp_val   <= disp_val_nx;
            disp_dp    <= disp_dp_nx;
            frame_done <= frame_wrap;
            // Outputs (and the live blank_lz sample) only move on a digit step.
            if (upd) begin
                seg <= lane_seg[idx_nx];
                dp  <= disp_dp_nx[idx_nx];
                an  <= DIGITS'(1) << idx_nx;
            end
        end
    end
endmodule
